vga_timing: RTL and testbench
=============================

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL have parameter PIX_DIV, default 1, clk cycles per pixel (1 or 2; 2 for a 50 MHz clk).
REQ-002 SHALL have parameter H_VIS/H_FP/H_SYNC/H_BP, defaults 640/16/96/48, horizontal segment lengths in pixels.
REQ-003 SHALL have parameter V_VIS/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, vertical segment lengths in lines.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 x  output  10  current horizontal pixel counter, 0..H_total-1.
REQ-007 y  output  10  current vertical line counter, 0..V_total-1; sprite consumers use y[8:0].
REQ-008 pix_tick  output  1  high for one clk per pixel period.
REQ-009 active  output  1  combinational, x<H_VIS && y<V_VIS.
REQ-010 line_start  output  1  one-clk pulse on the pix_tick where x wraps to 0.
REQ-011 frame_start  output  1  one-clk pulse on the pix_tick where x and y both wrap to 0.
REQ-012 rgb_in  input  6  composited colour {r,g,b} for current x,y (valid same cycle).
REQ-013 rgb_en  input  1  OR of sprite enables; low = background.
REQ-014 r, g, b  output  2 each  registered pixel colour.
REQ-015 hsync, vsync  output  1 each  registered, active-low sync.

Function
REQ-016 Divider SHALL count 0..PIX_DIV-1; pix_tick high when divider equals PIX_DIV-1 (always high for PIX_DIV=1).
REQ-017 On pix_tick, x SHALL increment; x SHALL wrap to 0 after H_total-1 (800).
REQ-018 On pix_tick with x==H_total-1, y SHALL increment, wrapping to 0 after V_total-1 (525).
REQ-019 x, y SHALL hold between pix_ticks; no counter SHALL exceed its total.
REQ-020 On pix_tick, r,g,b SHALL load rgb_in if active && rgb_en, else 0 (x/y-dependent 1-tick latency; undefined rgb_in while rgb_en low never propagates).
REQ-021 On pix_tick, hsync SHALL load 0 iff H_VIS+H_FP <= x < H_VIS+H_FP+H_SYNC (656..751), else 1.
REQ-022 On pix_tick, vsync SHALL load 0 iff V_VIS+V_FP <= y < V_VIS+V_FP+V_SYNC (490..491), else 1.
REQ-023 r,g,b, hsync, vsync SHALL therefore share identical one-pixel latency relative to x,y.
REQ-024 line_start, frame_start SHALL be registered, asserted the clk after the wrap tick, width exactly one clk.
REQ-025 Arithmetic: counters 10-bit unsigned; compare constants sized to 10 bits; no signed math.

Reset
REQ-026 While rst high at a clk edge: divider=0, x=0, y=0, r=g=b=0, hsync=vsync=1, line_start=frame_start=0.
REQ-027 rst mid-frame SHALL abort the frame immediately; first pix_tick after release SHALL advance x from 0 to 1.
REQ-028 rst SHALL dominate pix_tick in the same cycle.

Structure
REQ-029 Timing constants and derived H_total/V_total, sync start/end SHALL live in shared package vga_pkg, reused by sprite and game logic.
REQ-030 One sub-module, vga_axis_counter (count, wrap, sync window compare), SHALL be instantiated twice (H, V).

Verification
REQ-031 PIX_DIV=1, release rst, run 800 clk -> x reaches 799, then 0; y=1; line_start one clk later.
REQ-032 Run 420000 clk -> frame_start pulses exactly at clk 420000+1, once; x=y=0.
REQ-033 Sample hsync per line -> low for exactly 96 pix_ticks starting at registered x=657 view; vsync low for exactly 2 lines (y 490,491) -> 1600 clk.
REQ-034 rgb_en=1, rgb_in=6'b110011 at x=100,y=100 -> r=11,g=00,b=11 next tick; same at x=700 -> rgb=0.
REQ-035 PIX_DIV=2 -> pix_tick every 2nd clk, frame = 840000 clk; x,y stable between ticks.
REQ-036 Assert rst at x=300,y=200 for 1 clk -> next cycle x=y=0, hsync=vsync=1, rgb=0; frame resumes cleanly.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants, derived totals/sync windows and helpers shared by video, sprite and game logic.
package vga_pkg;
  localparam int unsigned H_VIS = 640, H_FP = 16, H_SYNC = 96, H_BP = 48;
  localparam int unsigned V_VIS = 480, V_FP = 10, V_SYNC = 2, V_BP = 33;
  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_VIS + H_FP, HS_END = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VIS + V_FP, VS_END = VS_START + V_SYNC;
  typedef logic [9:0] coord_t;
  function automatic logic in_win(coord_t c, int unsigned lo, int unsigned hi);
    return c >= 10'(lo) && c < 10'(hi);
  endfunction
endpackage

// File: rtl/vga_timing_if.sv
// vga_timing_if: pixel position, sync and colour bundle between the timing core and its pixel producers.
interface vga_timing_if;
  import vga_pkg::*;
  coord_t x, y;
  logic pix_tick, active, line_start, frame_start;
  logic [5:0] rgb_in;
  logic rgb_en;
  logic [1:0] r, g, b;
  logic hsync, vsync;
  modport master(output x, y, pix_tick, active, line_start, frame_start, r, g, b, hsync, vsync,
                 input rgb_in, rgb_en);
  modport slave(input x, y, pix_tick, active, line_start, frame_start, r, g, b, hsync, vsync,
                output rgb_in, rgb_en);
endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one scan axis; counts on i_en, wraps at TOTAL-1, flags the active-low sync window.
module vga_axis_counter import vga_pkg::*; #(
  parameter int unsigned TOTAL = H_TOTAL,
  parameter int unsigned SYNC_START = HS_START,
  parameter int unsigned SYNC_END = HS_END
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_en,
  output coord_t o_count,
  output logic   o_wrap,
  output logic   o_sync_n
);
  coord_t r_count;
  assign o_count = r_count;
  assign o_wrap = r_count == 10'(TOTAL - 1);
  assign o_sync_n = !in_win(r_count, SYNC_START, SYNC_END);
  always_ff @(posedge clk)
    if (rst) r_count <= '0;
    else if (i_en) r_count <= o_wrap ? '0 : r_count + 10'd1;
endmodule

// File: rtl/vga_timing.sv
// vga_timing: VGA raster generator; pixel divider, H/V counters, and registered colour/sync sharing one pixel of latency.
module vga_timing import vga_pkg::coord_t; #(
  parameter int unsigned PIX_DIV = 1,
  parameter int unsigned H_VIS = vga_pkg::H_VIS,
  parameter int unsigned H_FP = vga_pkg::H_FP,
  parameter int unsigned H_SYNC = vga_pkg::H_SYNC,
  parameter int unsigned H_BP = vga_pkg::H_BP,
  parameter int unsigned V_VIS = vga_pkg::V_VIS,
  parameter int unsigned V_FP = vga_pkg::V_FP,
  parameter int unsigned V_SYNC = vga_pkg::V_SYNC,
  parameter int unsigned V_BP = vga_pkg::V_BP
) (
  input logic clk,
  input logic rst,
  vga_timing_if.master vga
);
  localparam int unsigned DW = PIX_DIV > 1 ? $clog2(PIX_DIV) : 1;
  logic [DW-1:0] r_div;
  logic [5:0] r_rgb;
  logic r_hs, r_vs, r_ls, r_fs;
  logic w_tick, w_active, w_hwrap, w_vwrap, w_hs_n, w_vs_n;
  coord_t w_x, w_y;
  assign w_tick = r_div == DW'(PIX_DIV - 1);
  assign w_active = w_x < 10'(H_VIS) && w_y < 10'(V_VIS);
  vga_axis_counter #(
    .TOTAL(H_VIS + H_FP + H_SYNC + H_BP),
    .SYNC_START(H_VIS + H_FP),
    .SYNC_END(H_VIS + H_FP + H_SYNC)
  ) u_h (.clk(clk), .rst(rst), .i_en(w_tick), .o_count(w_x), .o_wrap(w_hwrap), .o_sync_n(w_hs_n));
  vga_axis_counter #(
    .TOTAL(V_VIS + V_FP + V_SYNC + V_BP),
    .SYNC_START(V_VIS + V_FP),
    .SYNC_END(V_VIS + V_FP + V_SYNC)
  ) u_v (.clk(clk), .rst(rst), .i_en(w_tick && w_hwrap), .o_count(w_y), .o_wrap(w_vwrap), .o_sync_n(w_vs_n));
  always_ff @(posedge clk)
    if (rst) begin
      r_div <= '0;
      r_rgb <= '0;
      r_hs <= 1'b1;
      r_vs <= 1'b1;
      r_ls <= 1'b0;
      r_fs <= 1'b0;
    end else begin
      r_div <= w_tick ? '0 : r_div + DW'(1);
      r_ls <= w_tick && w_hwrap;
      r_fs <= w_tick && w_hwrap && w_vwrap;
      // colour and sync sample the position being left, so all five outputs lag x,y by one pixel
      if (w_tick) begin
        r_rgb <= w_active && vga.rgb_en ? vga.rgb_in : '0;
        r_hs <= w_hs_n;
        r_vs <= w_vs_n;
      end
    end
  assign vga.x = w_x;
  assign vga.y = w_y;
  assign vga.pix_tick = w_tick;
  assign vga.active = w_active;
  assign vga.line_start = r_ls;
  assign vga.frame_start = r_fs;
  assign {vga.r, vga.g, vga.b} = r_rgb;
  assign vga.hsync = r_hs;
  assign vga.vsync = r_vs;
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: scaled-raster bench; d1 (PIX_DIV=1) and d2 (PIX_DIV=2) checked each clk against a queued reference model.
module tb_vga_timing;
  import vga_pkg::*;
  localparam int HV = 20, HF = 3, HS = 5, HB = 4, HT = HV + HF + HS + HB;
  localparam int VV = 12, VF = 2, VS = 2, VB = 3, VT = VV + VF + VS + VB;
  typedef struct packed {
    coord_t x; coord_t y; logic [5:0] rgb;
    logic hs, vs, ls, fs, act, tick;
  } out_t;
  typedef struct packed { out_t o; logic [1:0] div; } st_t;
  typedef struct packed { out_t a; out_t b; } exp_t;
  logic clk = 0, rst = 1, rnd = 1;
  logic [5:0] rgb_in = '0;
  logic rgb_en = 0;
  int n_chk = 0, n_fail = 0;
  st_t m1 = '0, m2 = '0;
  exp_t q[$];
  out_t o1, o2;
  vga_timing_if v1();
  vga_timing_if v2();
  assign v1.rgb_in = rgb_in;
  assign v1.rgb_en = rgb_en;
  assign v2.rgb_in = rgb_in;
  assign v2.rgb_en = rgb_en;
  assign o1 = {v1.x, v1.y, v1.r, v1.g, v1.b, v1.hsync, v1.vsync, v1.line_start, v1.frame_start, v1.active, v1.pix_tick};
  assign o2 = {v2.x, v2.y, v2.r, v2.g, v2.b, v2.hsync, v2.vsync, v2.line_start, v2.frame_start, v2.active, v2.pix_tick};
  vga_timing #(.PIX_DIV(1), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
               .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) d1 (.clk(clk), .rst(rst), .vga(v1));
  vga_timing #(.PIX_DIV(2), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
               .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) d2 (.clk(clk), .rst(rst), .vga(v2));
  always #5 clk = ~clk;

  function automatic st_t nxt(st_t s, int pd, logic r, logic [5:0] rin, logic en);
    st_t n;
    logic tk;
    n = s;
    tk = int'(s.div) == pd - 1;
    if (r) begin
      n.o.x = '0; n.o.y = '0; n.o.rgb = '0; n.o.hs = 1; n.o.vs = 1; n.o.ls = 0; n.o.fs = 0; n.div = '0;
    end else begin
      n.div = tk ? 2'd0 : s.div + 2'd1;
      n.o.ls = tk && s.o.x == HT - 1;
      n.o.fs = n.o.ls && s.o.y == VT - 1;
      if (tk) begin
        n.o.rgb = (s.o.x < HV && s.o.y < VV && en) ? rin : 6'd0;
        n.o.hs = !(s.o.x >= HV + HF && s.o.x < HV + HF + HS);
        n.o.vs = !(s.o.y >= VV + VF && s.o.y < VV + VF + VS);
        n.o.x = s.o.x == HT - 1 ? 10'd0 : s.o.x + 10'd1;
        n.o.y = s.o.x != HT - 1 ? s.o.y : (s.o.y == VT - 1 ? 10'd0 : s.o.y + 10'd1);
      end
    end
    n.o.act = n.o.x < HV && n.o.y < VV;
    n.o.tick = int'(n.div) == pd - 1;
    return n;
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    exp_t e;
    if (rnd) begin
      rgb_in = 6'($urandom);
      rgb_en = 1'($urandom);
    end
    m1 = nxt(m1, 1, rst, rgb_in, rgb_en);
    m2 = nxt(m2, 2, rst, rgb_in, rgb_en);
    q.push_back({m1.o, m2.o});
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("sb_d1", 64'(o1), 64'(e.a));
    chk("sb_d2", 64'(o2), 64'(e.b));
  endtask

  task automatic run_to(int x, int y, int budget, string tag);
    int k = 0;
    while (!(int'(v1.x) == x && int'(v1.y) == y) && k < budget) begin
      step();
      k++;
    end
    chk(tag, 64'(int'(v1.x) == x && int'(v1.y) == y), 64'(1));
  endtask

  initial begin
    int cnt, first, fs_cnt, k;
    repeat (3) step();
    chk("rst_state", 64'({v1.x, v1.y, v1.r, v1.g, v1.b, v1.hsync, v1.vsync, v1.line_start, v1.frame_start}), 64'(7'b1100));
    rst = 0;
    repeat (HT - 1) step();
    chk("x_last", 64'(v1.x), 64'(HT - 1));
    step();
    chk("x_wrap", 64'({v1.x, v1.y, v1.line_start}), 64'({10'd0, 10'd1, 1'b1}));
    step();
    chk("ls_width", 64'(v1.line_start), 64'(0));
    run_to(5, 5, 2000, "reach_5_5");
    rnd = 0; rgb_en = 1; rgb_in = 6'b110011;
    step();
    chk("rgb_vis", 64'({v1.r, v1.g, v1.b}), 64'(6'b110011));
    run_to(29, 5, 2000, "reach_29_5");
    step();
    chk("rgb_blank", 64'({v1.r, v1.g, v1.b}), 64'(0));
    rgb_en = 0;
    run_to(6, 7, 2000, "reach_6_7");
    step();
    chk("rgb_en_low", 64'({v1.r, v1.g, v1.b}), 64'(0));
    rnd = 1;
    run_to(0, 8, 2000, "reach_0_8");
    cnt = 0; first = -1;
    for (int i = 0; i < HT; i++) begin
      step();
      if (!v1.hsync) begin
        cnt++;
        if (first < 0) first = int'(v1.x);
      end
    end
    chk("hs_len", 64'(cnt), 64'(HS));
    chk("hs_first_x", 64'(first), 64'(HV + HF + 1));
    k = 0;
    while (!v1.frame_start && k < 2000) begin step(); k++; end
    chk("fs_found", 64'(v1.frame_start), 64'(1));
    cnt = 0; fs_cnt = 0;
    for (int i = 0; i < HT * VT; i++) begin
      step();
      if (!v1.vsync) cnt++;
      if (v1.frame_start) fs_cnt++;
    end
    chk("vs_len", 64'(cnt), 64'(VS * HT));
    chk("fs_once", 64'(fs_cnt), 64'(1));
    chk("fs_period", 64'({v1.frame_start, v1.x, v1.y}), 64'({1'b1, 20'd0}));
    k = 0;
    while (!v2.frame_start && k < 3000) begin step(); k++; end
    chk("fs2_found", 64'(v2.frame_start), 64'(1));
    k = 0; cnt = 0;
    do begin
      step();
      k++;
      if (v2.pix_tick) cnt++;
    end while (!v2.frame_start && k < 3000);
    chk("fs2_period", 64'(k), 64'(2 * HT * VT));
    chk("tick2_count", 64'(cnt), 64'(HT * VT));
    run_to(25, 15, 2000, "reach_25_15");
    chk("pre_rst_sync", 64'({v1.hsync, v1.vsync}), 64'(0));
    rst = 1;
    step();
    rst = 0;
    chk("mid_rst", 64'({v1.x, v1.y, v1.r, v1.g, v1.b, v1.hsync, v1.vsync}), 64'(2'b11));
    step();
    chk("resume_x", 64'(v1.x), 64'(1));
    repeat (HT * VT + 50) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
